// File: rtl/frame_rgb_mean_pkg.sv
// Shared constants, FSM state type and frame-size helper for the per-frame RGB mean estimator.
package frame_rgb_mean_pkg;

  localparam int CH_W        = 8;
  localparam int NLINE_DEF   = 349;
  localparam int NSCREEN_DEF = 349;
  localparam int N_PIX       = NLINE_DEF * NSCREEN_DEF;
  localparam int N_HALF      = N_PIX / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int pix_per_frame(input int nline, input int nscreen);
    return nline * nscreen;
  endfunction

endpackage

// File: rtl/frame_rgb_mean_if.sv
// 24-bit RGB AXI-Stream tap (no tready): the mean estimator only observes the stream.
interface frame_rgb_mean_if;
  import frame_rgb_mean_pkg::*;

  logic                  tvalid;
  logic                  tuser;
  logic                  tlast;
  logic [3*CH_W-1:0]     tdata;

  modport master (output tvalid, output tuser, output tlast, output tdata);
  modport slave  (input  tvalid, input  tuser, input  tlast, input  tdata);

endinterface

// File: rtl/seq_div_u.sv
// Unsigned restoring divider by a constant, one quotient bit per step; the step count is owned by the parent.
module seq_div_u #(
  parameter int ACC_W   = 26,
  parameter int DIVISOR = 1,
  parameter int OUT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             last,
  input  logic [ACC_W-1:0] dividend,
  output logic [OUT_W-1:0] quotient,
  output logic             done
);

  localparam logic [ACC_W-1:0] DIV_C = ACC_W'(DIVISOR);

  logic [ACC_W-1:0] rem_r;
  logic [ACC_W-1:0] quo_r;
  logic [ACC_W:0]   trial_s;
  logic [ACC_W-1:0] diff_s;
  logic             ge_s;

  // Trial subtraction; the difference always fits ACC_W bits because the divisor does.
  always_comb begin
    trial_s = {rem_r, quo_r[ACC_W-1]};
    ge_s    = (trial_s >= {1'b0, DIV_C});
    diff_s  = trial_s[ACC_W-1:0] - DIV_C;
  end

  // Dividend shifts out of quo_r as quotient bits shift in.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r <= '0;
      quo_r <= '0;
      done  <= 1'b0;
    end else if (start) begin
      rem_r <= '0;
      quo_r <= dividend;
      done  <= 1'b0;
    end else if (step) begin
      rem_r <= ge_s ? diff_s : trial_s[ACC_W-1:0];
      quo_r <= {quo_r[ACC_W-2:0], ge_s};
      done  <= last;
    end else begin
      done  <= 1'b0;
    end
  end

  assign quotient = quo_r[OUT_W-1:0];

endmodule

// File: rtl/frame_rgb_mean.sv
// Per-frame RGB channel mean estimator: accumulates each channel over a frame, then divides by the
// pixel count with three parallel sequential dividers and publishes rounded 8-bit means.
module frame_rgb_mean
  import frame_rgb_mean_pkg::*;
#(
  parameter int NLINE   = NLINE_DEF,
  parameter int NSCREEN = NSCREEN_DEF,
  parameter int ACC_W   = 26
) (
  input  logic                clk,
  input  logic                rst,
  frame_rgb_mean_if.slave     s_axis,
  output logic [CH_W-1:0]     mean_r,
  output logic [CH_W-1:0]     mean_g,
  output logic [CH_W-1:0]     mean_b,
  output logic                mean_valid,
  output logic                mean_err,
  output logic                busy,
  output logic                frame_drop
);

  localparam int N_PIX_L  = pix_per_frame(NLINE, NSCREEN);
  localparam int N_HALF_L = N_PIX_L / 2;
  localparam int LINE_W   = $clog2(NSCREEN + 1);
  localparam int PIX_W    = $clog2(NLINE + 1);
  localparam int ITER_W   = $clog2(ACC_W + 1);

  state_t             state_r, state_next;
  logic [ACC_W-1:0]   acc_r      [3];
  logic [ACC_W-1:0]   acc_base_s [3];
  logic [ACC_W-1:0]   ch_s       [3];
  logic [ACC_W-1:0]   sum_s      [3];
  logic [CH_W-1:0]    quo_s      [3];
  logic [2:0]         done_s;
  logic [ACC_W-1:0]   beat_cnt_r, beat_base_s;
  logic [LINE_W-1:0]  line_cnt_r, line_base_s;
  logic [PIX_W-1:0]   pix_cnt_r,  pix_base_s;
  logic               seen_r, seen_base_s;
  logic               eof_s, accept_s, err_s, err_r;
  logic               step_s, last_s, div_done_s;
  logic [ITER_W-1:0]  iter_r;

  // A tuser beat restarts the frame, so counters are evaluated against a restarted base.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ch_s[i] = ACC_W'(s_axis.tdata[(2-i)*CH_W +: CH_W]);
    end
    if (s_axis.tuser) begin
      for (int i = 0; i < 3; i++) acc_base_s[i] = '0;
      beat_base_s = '0;
      line_base_s = '0;
      pix_base_s  = '0;
      seen_base_s = 1'b1;
    end else begin
      for (int i = 0; i < 3; i++) acc_base_s[i] = acc_r[i];
      beat_base_s = beat_cnt_r;
      line_base_s = line_cnt_r;
      pix_base_s  = pix_cnt_r;
      seen_base_s = seen_r;
    end
    eof_s = s_axis.tvalid & s_axis.tlast & (line_base_s == LINE_W'(NSCREEN - 1));
    for (int i = 0; i < 3; i++) begin
      sum_s[i] = acc_base_s[i] + ch_s[i] + ACC_W'(N_HALF_L);
    end
    err_s    = ((beat_base_s + ACC_W'(1)) != ACC_W'(N_PIX_L)) | ~seen_base_s;
    accept_s = eof_s & (state_r == IDLE);
  end

  // Frame accumulators and beat/line/pixel counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) acc_r[i] <= '0;
      beat_cnt_r <= '0;
      line_cnt_r <= '0;
      pix_cnt_r  <= '0;
      seen_r     <= 1'b0;
    end else if (s_axis.tvalid) begin
      if (eof_s) begin
        for (int i = 0; i < 3; i++) acc_r[i] <= '0;
        beat_cnt_r <= '0;
        line_cnt_r <= '0;
        pix_cnt_r  <= '0;
        seen_r     <= 1'b0;
      end else begin
        for (int i = 0; i < 3; i++) acc_r[i] <= acc_base_s[i] + ch_s[i];
        beat_cnt_r <= beat_base_s + ACC_W'(1);
        seen_r     <= seen_base_s;
        if (s_axis.tlast) begin
          line_cnt_r <= line_base_s + LINE_W'(1);
          pix_cnt_r  <= '0;
        end else begin
          line_cnt_r <= line_base_s;
          pix_cnt_r  <= pix_base_s + PIX_W'(1);
        end
      end
    end
  end

  // The dividers load the rounded sums directly on the EOF edge, so they double as the snapshot.
  for (genvar g = 0; g < 3; g++) begin : g_div
    seq_div_u #(
      .ACC_W   (ACC_W),
      .DIVISOR (N_PIX_L),
      .OUT_W   (CH_W)
    ) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (accept_s),
      .step     (step_s),
      .last     (last_s),
      .dividend (sum_s[g]),
      .quotient (quo_s[g]),
      .done     (done_s[g])
    );
  end

  assign div_done_s = &done_s;

  // Next-state logic and divider stepping.
  always_comb begin
    state_next = state_r;
    step_s     = 1'b0;
    last_s     = (iter_r == ITER_W'(ACC_W - 1));
    case (state_r)
      IDLE: begin
        if (accept_s) state_next = DIV;
        else          state_next = IDLE;
      end
      DIV: begin
        if (div_done_s) begin
          state_next = DONE;
        end else begin
          state_next = DIV;
          step_s     = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, shared iteration counter and frame-error snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      iter_r  <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_next;
      if (accept_s) begin
        iter_r <= '0;
        err_r  <= err_s;
      end else if (step_s) begin
        iter_r <= iter_r + ITER_W'(1);
      end
    end
  end

  // Published results; means hold across malformed frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      mean_r     <= 8'd128;
      mean_g     <= 8'd128;
      mean_b     <= 8'd128;
      mean_valid <= 1'b0;
      mean_err   <= 1'b0;
      busy       <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      busy       <= (state_next != IDLE);
      frame_drop <= eof_s & (state_r != IDLE);
      if ((state_r == DIV) && div_done_s) begin
        mean_valid <= 1'b1;
        mean_err   <= err_r;
        if (!err_r) begin
          mean_r <= quo_s[0];
          mean_g <= quo_s[1];
          mean_b <= quo_s[2];
        end
      end else begin
        mean_valid <= 1'b0;
        mean_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_rgb_mean.sv
// Self-checking bench for frame_rgb_mean with a 4x3 frame: expected means are queued as frames are sent.
module tb_frame_rgb_mean;

  localparam int NL   = 4;
  localparam int NS   = 3;
  localparam int NPIX = NL * NS;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mean_r, mean_g, mean_b;
  logic       mean_valid, mean_err, busy, frame_drop;

  frame_rgb_mean_if s_axis ();

  frame_rgb_mean #(.NLINE(NL), .NSCREEN(NS), .ACC_W(26)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_axis     (s_axis),
    .mean_r     (mean_r),
    .mean_g     (mean_g),
    .mean_b     (mean_b),
    .mean_valid (mean_valid),
    .mean_err   (mean_err),
    .busy       (busy),
    .frame_drop (frame_drop)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   e0 = 0;
  int   asserts = 0;
  int   failures = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic user, input logic last);
    s_axis.tvalid = 1'b1;
    s_axis.tuser  = user;
    s_axis.tlast  = last;
    s_axis.tdata  = {r, g, b};
    @(posedge clk);
    #1;
    s_axis.tvalid = 1'b0;
    s_axis.tuser  = 1'b0;
    s_axis.tlast  = 1'b0;
    s_axis.tdata  = 24'd0;
  endtask

  task automatic send_frame(input logic [7:0] rv [NPIX], input logic [7:0] gv [NPIX],
                            input logic [7:0] bv [NPIX], input int gap_max);
    for (int i = 0; i < NPIX; i++) begin
      int gap;
      gap = int'($urandom_range(gap_max, 0));
      if (gap > 0) tick(gap);
      beat(rv[i], gv[i], bv[i], (i == 0), ((i % NL) == NL - 1));
    end
    e0 = cyc;
  endtask

  task automatic collect(output bit got, output exp_t obs, output int lat, output int width);
    got = 1'b0; obs = '0; lat = 0; width = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mean_valid) begin
        got = 1'b1;
        obs.r = mean_r; obs.g = mean_g; obs.b = mean_b; obs.err = mean_err;
        lat = cyc - e0;
        break;
      end
    end
    if (got) begin
      width = 1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (mean_valid) width++;
        else break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic quiet;
    rst = 1'b1;
    s_axis.tvalid = 1'b0; s_axis.tuser = 1'b0; s_axis.tlast = 1'b0; s_axis.tdata = 24'd0;
    tick(3);
    rst = 1'b0;
    tick(1);
    asserts++;
    if ({mean_r, mean_g, mean_b} !== {8'd128, 8'd128, 8'd128}) begin
      failures++;
      $display("FAIL reset_means: got %0d/%0d/%0d expected 128/128/128", mean_r, mean_g, mean_b);
    end
    quiet = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      quiet = quiet | mean_valid | busy | frame_drop | (mean_valid === 1'bx);
    end
    tick(1);
    asserts++;
    if (quiet !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_outputs: got activity=%b expected 0", quiet);
    end
  endtask

  task automatic check_result(input string name, input bit got, input exp_t obs,
                              input int lat, input int width, input bit chk_lat);
    exp_t ex;
    asserts++;
    if (!got) begin
      failures++;
      $display("FAIL %s_valid: no mean_valid within 200 cycles, expected one pulse", name);
    end else begin
      ex = sb.pop_front();
      asserts++;
      if ({obs.r, obs.g, obs.b} !== {ex.r, ex.g, ex.b}) begin
        failures++;
        $display("FAIL %s_means: got %0d/%0d/%0d expected %0d/%0d/%0d",
                 name, obs.r, obs.g, obs.b, ex.r, ex.g, ex.b);
      end
      asserts++;
      if (obs.err !== ex.err) begin
        failures++;
        $display("FAIL %s_err: got %b expected %b", name, obs.err, ex.err);
      end
      asserts++;
      if (width !== 1) begin
        failures++;
        $display("FAIL %s_pulse_width: got %0d expected 1", name, width);
      end
      if (chk_lat) begin
        asserts++;
        if (lat !== 27) begin
          failures++;
          $display("FAIL %s_latency: got %0d edges expected 27", name, lat);
        end
      end
    end
  endtask

  task automatic test_uniform();
    logic [7:0] rv [NPIX], gv [NPIX], bv [NPIX];
    bit got; exp_t obs; int lat, width;
    for (int i = 0; i < NPIX; i++) begin rv[i] = 8'd10; gv[i] = 8'd20; bv[i] = 8'd30; end
    sb.push_back('{r: 8'd10, g: 8'd20, b: 8'd30, err: 1'b0});
    send_frame(rv, gv, bv, 0);
    @(negedge clk);
    asserts++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL uniform_busy: got %b expected 1", busy);
    end
    collect(got, obs, lat, width);
    check_result("uniform", got, obs, lat, width, 1'b1);
  endtask

  task automatic test_rounding();
    logic [7:0] rv [NPIX], gv [NPIX], bv [NPIX];
    bit got; exp_t obs; int lat, width;
    for (int i = 0; i < NPIX; i++) begin
      rv[i] = 8'(i); gv[i] = 8'd255; bv[i] = 8'(i % 2);
    end
    sb.push_back('{r: 8'd6, g: 8'd255, b: 8'd1, err: 1'b0});
    send_frame(rv, gv, bv, 3);
    collect(got, obs, lat, width);
    check_result("rounding", got, obs, lat, width, 1'b1);
  endtask

  task automatic test_abandoned();
    logic [7:0] rv [NPIX], gv [NPIX], bv [NPIX];
    bit got; exp_t obs; int lat, width;
    for (int i = 0; i < 5; i++) beat(8'd200, 8'd200, 8'd200, (i == 0), (i == 3));
    for (int i = 0; i < NPIX; i++) begin rv[i] = 8'd50; gv[i] = 8'd50; bv[i] = 8'd50; end
    sb.push_back('{r: 8'd50, g: 8'd50, b: 8'd50, err: 1'b0});
    send_frame(rv, gv, bv, 1);
    collect(got, obs, lat, width);
    check_result("abandoned", got, obs, lat, width, 1'b1);
  endtask

  task automatic test_malformed();
    bit got; exp_t obs; int lat, width;
    sb.push_back('{r: 8'd50, g: 8'd50, b: 8'd50, err: 1'b1});
    for (int l = 0; l < NS; l++) begin
      int len;
      len = (l == NS - 1) ? NL - 1 : NL;
      for (int p = 0; p < len; p++) beat(8'd99, 8'd99, 8'd99, (l == 0 && p == 0), (p == len - 1));
    end
    e0 = cyc;
    collect(got, obs, lat, width);
    check_result("malformed", got, obs, lat, width, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] rv [NPIX], gv [NPIX], bv [NPIX];
    bit got; exp_t obs; int lat, width;
    for (int i = 0; i < NPIX; i++) begin rv[i] = 8'd80; gv[i] = 8'd90; bv[i] = 8'd100; end
    sb.push_back('{r: 8'd80, g: 8'd90, b: 8'd100, err: 1'b0});
    send_frame(rv, gv, bv, 0);
    tick(2);
    for (int i = 0; i < NS; i++) beat(8'd7, 8'd7, 8'd7, 1'b0, 1'b1);
    asserts++;
    if (frame_drop !== 1'b1) begin
      failures++;
      $display("FAIL drop_pulse: got frame_drop=%b expected 1", frame_drop);
    end
    tick(1);
    asserts++;
    if (frame_drop !== 1'b0) begin
      failures++;
      $display("FAIL drop_single: got frame_drop=%b expected 0", frame_drop);
    end
    collect(got, obs, lat, width);
    check_result("drop_first_result", got, obs, lat, width, 1'b1);
  endtask

  task automatic test_reset_during_div();
    logic [7:0] rv [NPIX], gv [NPIX], bv [NPIX];
    logic seen;
    for (int i = 0; i < NPIX; i++) begin rv[i] = 8'd5; gv[i] = 8'd5; bv[i] = 8'd5; end
    send_frame(rv, gv, bv, 0);
    tick(10);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    asserts++;
    if ({mean_r, mean_g, mean_b, busy} !== {8'd128, 8'd128, 8'd128, 1'b0}) begin
      failures++;
      $display("FAIL rst_div_state: got %0d/%0d/%0d busy=%b expected 128/128/128 busy=0",
               mean_r, mean_g, mean_b, busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | mean_valid;
    end
    tick(1);
    asserts++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL rst_div_no_valid: got mean_valid=%b expected 0", seen);
    end
    asserts++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_empty: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_rounding();
    test_abandoned();
    test_malformed();
    test_back_to_back();
    test_reset_during_div();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
